frame_read_arbiter: RTL and testbench

FRAME_READ_ARBITER -- requirements
Module: frame_read_arbiter

---
 rtl/frame_read_arbiter.sv | 112 +++++++++++
 tb/tb_frame_read_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/frame_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : frame_read_arbiter
//  Purpose  : Round-robin arbiter that shares one BRAM read port between two
//             requesters and routes each read return to its issuer.
//             Optional macro ARB_STATS_EN builds saturating grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module frame_read_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              frame_rdy,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
);

  logic              last_q;
  logic              last_d;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [RD_LAT-1:0] idx_q;
  logic [RD_LAT-1:0] idx_d;

  // last_q=1 means requester 0 wins the next contended cycle.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    mem_en   = 1'b0;
    mem_addr = '0;
    last_d   = last_q;
    if (!reset && frame_rdy) begin
      if (req0 && (!req1 || last_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    mem_en = gnt0 | gnt1;
    if (gnt0) begin
      mem_addr = addr0;
      last_d   = 1'b0;
    end else if (gnt1) begin
      mem_addr = addr1;
      last_d   = 1'b1;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_shift_single
      assign vld_d = mem_en;
      assign idx_d = gnt1;
    end else begin : g_shift_multi
      assign vld_d = {vld_q[RD_LAT-2:0], mem_en};
      assign idx_d = {idx_q[RD_LAT-2:0], gnt1};
    end
  endgenerate

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
      vld_q  <= '0;
      idx_q  <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
    end
  end

  assign rvalid0 = vld_q[RD_LAT-1] & ~idx_q[RD_LAT-1];
  assign rvalid1 = vld_q[RD_LAT-1] &  idx_q[RD_LAT-1];
  assign rdata   = vld_q[RD_LAT-1] ? mem_dout : '0;

`ifdef ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_read_arbiter
//  Purpose  : Randomized scoreboard bench for frame_read_arbiter (RD_LAT=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_read_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 3;

  logic              clk_50 = 1'b0;
  logic              reset = 1'b1;
  logic              frame_rdy = 1'b0;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_en;
  logic [DATA_W-1:0] rdata, mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       gnt_cnt0, gnt_cnt1;

  frame_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_50(clk_50), .reset(reset), .frame_rdy(frame_rdy),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Frame contents are a fixed hash of the address; idle slots return noise.
  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
  endfunction

  logic [DATA_W-1:0] dly [RD_LAT];
  always @(posedge clk_50) begin
    dly[0] <= mem_en ? pix(mem_addr) : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end
  assign mem_dout = dly[RD_LAT-1];

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Requester-side model state and reference arbitration history.
  bit                act [2];
  logic [ADDR_W-1:0] adr [2];
  int                p_req [2];
  int                p_frm;
  int                prev_w = 1;
  int                exp_cnt [2];

  task automatic step(input bit r);
    int                w;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ecnt;
    @(negedge clk_50);
    for (int i = 0; i < 2; i++) begin
      if (!act[i] && ($urandom_range(99) < p_req[i])) begin
        act[i] = 1'b1;
        adr[i] = ADDR_W'($urandom_range(640*480-1));
      end
    end
    reset     = r;
    req0      = act[0];
    addr0     = adr[0];
    req1      = act[1];
    addr1     = adr[1];
    frame_rdy = ($urandom_range(99) < p_frm);
    #1;
    if (reset) begin
      check("reset_outputs",
            {gnt0, gnt1, mem_en, mem_addr, rvalid0, rvalid1, rdata, gnt_cnt0, gnt_cnt1}, '0);
      sb.delete();
      prev_w     = 1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
    end else begin
      w = -1;
      if (frame_rdy) begin
        if (act[0] && act[1]) w = 1 - prev_w;  // whoever did not win most recently
        else if (act[0])      w = 0;
        else if (act[1])      w = 1;
      end
      ea = (w == 0) ? adr[0] : (w == 1) ? adr[1] : '0;
      check("grant", {gnt0, gnt1, mem_en, mem_addr}, {w == 0, w == 1, w >= 0, ea});
`ifdef ARB_STATS_EN
      ecnt = {16'(exp_cnt[0]), 16'(exp_cnt[1])};
`else
      ecnt = '0;
`endif
      check("gnt_cnt", {gnt_cnt0, gnt_cnt1}, ecnt);
      if (w >= 0) begin
        sb.push_back('{idx: w, data: pix(adr[w]), due: cyc + RD_LAT});
        prev_w = w;
        act[w] = 1'b0;
        if (exp_cnt[w] < 65535) exp_cnt[w]++;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a return is presented or overdue.
  always @(negedge clk_50) begin
    exp_t e;
    #2;
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {rvalid0, rvalid1}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("return", {32'(cyc), rvalid0, rvalid1, rdata},
              {32'(e.due), e.idx == 0, e.idx == 1, e.data});
      end
    end else begin
      check("idle_rdata", rdata, '0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_rvalid", {rvalid0, rvalid1}, {e.idx == 0, e.idx == 1});
      end
    end
  end

  initial begin
    p_req[0] = 100;
    p_req[1] = 100;
    p_frm    = 100;
    repeat (3) step(1'b1);
    // Contended from the first cycle: expect 0,1,0,1,0,1.
    repeat (6) step(1'b0);
    // Frame not ready: no grants while both wait.
    p_frm = 0;
    repeat (5) step(1'b0);
    p_frm = 100;
    repeat (4) step(1'b0);
    // Drain, then a lone directed read at address 1000.
    p_req[0] = 0;
    p_req[1] = 0;
    repeat (RD_LAT + 4) step(1'b0);
    act[0] = 1'b1;
    adr[0] = 19'd1000;
    repeat (RD_LAT + 2) step(1'b0);
    // Randomized traffic with a reset dropped onto in-flight reads.
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) begin
        p_req[0] = 30 * int'($urandom_range(3)) + ($urandom_range(1) ? 10 : 0);
        p_req[1] = 30 * int'($urandom_range(3)) + ($urandom_range(1) ? 10 : 0);
        p_frm    = ($urandom_range(2) == 0) ? 60 : 100;
      end
      if (k == 2000) begin
        p_req[0] = 100;
        p_req[1] = 100;
        p_frm    = 100;
      end
      step((k == 2005) || (k == 2006));
    end
    p_req[0] = 0;
    p_req[1] = 0;
    p_frm    = 100;
    repeat (RD_LAT + 4) step(1'b0);
    check("scoreboard_drained", 64'(sb.size()), '0);
    // Long single-requester run to push the counter into saturation.
    p_req[0] = 100;
    repeat (66000) step(1'b0);
    step(1'b0);
    p_req[0] = 0;
    repeat (RD_LAT + 3) step(1'b0);
    check("scoreboard_final", 64'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
